demux32_burst_writer: RTL
=========================

# demux32_burst_writer

Sequential 1:32 demultiplexer, the write-side counterpart of the 32:1 read mux. It accepts a burst command (start slot, beat count), then takes a valid/ready data stream and scatters the beats into 32 N-bit output registers, auto-incrementing the slot pointer with wrap-around. It sits in front of register-file and lookup-table storage whose read side is the 32:1 mux.

## Interface
Parameters:
- N, default 1, data width per slot.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- cmd_valid  input  1  burst command offered.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_select  input  5  first slot to write.
- cmd_count  input  6  beats in burst; 0 = empty burst; 33-63 saturate to 32.
- in_valid  input  1  data beat offered.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_data  input  N  beat payload.
- out  output  32*N  slot registers; slot i at out[i*N +: N].
- wr_strobe  output  32  one-hot: the slot updated this cycle.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

## Operation
- States: S_IDLE, S_BURST.
- S_IDLE: cmd_ready=1, in_ready=0, busy=0. On command handshake:
  - count 0: stay S_IDLE, pulse done next cycle, no slot written.
  - else: ptr <= cmd_select, remaining <= min(cmd_count, 32), go S_BURST.
- S_BURST: cmd_ready=0, in_ready=1, busy=1. Each beat handshake:
  - slot ptr <= in_data; wr_strobe[ptr] pulses; all other slots hold.
  - ptr <= ptr + 1, 5-bit wrap (31 -> 0).
  - remaining <= remaining - 1; if remaining was 1 -> S_IDLE, done pulses.
- in_valid low in S_BURST: stall, no state change, no write.
- cmd_valid in S_BURST is ignored (not accepted, not queued).
- in_valid in S_IDLE is ignored; in_data not sampled.
- Count 32 from any start covers every slot exactly once.
- Slots hold value indefinitely between bursts; no clear except reset.

## Timing
- Reset (async, rst_n low): state S_IDLE, ptr 0, remaining 0, out all 0, wr_strobe 0, done 0, busy 0, cmd_ready 1, in_ready 0.
- Reset mid-burst aborts: slots return to 0, no done pulse.
- cmd_ready, in_ready, busy are decoded from state register only; no combinational path from any input.
- Write latency 1: beat handshake at edge k -> out slot and wr_strobe visible after edge k (cycle k+1), strobe high exactly one cycle.
- Throughput one beat per cycle while in_valid held.
- done asserts the same cycle as the last slot update (cycle after last handshake); count-0 done is the cycle after command handshake.
- Back-to-back: cmd_ready is high in the cycle done is high; next command accepted there with no bubble.
- done and wr_strobe are registered outputs.

## Structure
- Package demux_pkg: SLOTS=32, SEL_W=5, CNT_W=6, enum state_t {S_IDLE, S_BURST}.
- Sub-module decoder_5_to_32 (5-bit ptr + enable -> one-hot 32) generating per-slot write enables, gated by beat handshake; enables also registered into wr_strobe.
- Slot storage: 32 N-bit enabled flops in a generate loop.

## Test plan
- Reset: hold rst_n low mid-clock -> all outputs at reset values immediately, independent of clk.
- N=8, cmd select=3 count=4, beats 0xA1..0xA4 back-to-back -> slots 3..6 = A1..A4, wr_strobe 0x08,0x10,0x20,0x40 on successive cycles, done with last update, other slots 0.
- Wrap: select=30 count=4, beats 1,2,3,4 -> slot30=1, slot31=2, slot0=3, slot1=4; ptr wraps with no gap.
- Stalls and ignores: select=0 count=3, in_valid toggled 1,0,1,0,1; cmd_valid held high throughout -> exactly 3 writes to slots 0..2, no second command accepted until done, then accepted in done cycle.
- Edge counts: count=0 -> done one cycle after handshake, no strobes; count=45 from select 7 -> exactly 32 writes, every slot written once, done after 32nd.
- Reset mid-burst: select=0 count=8, assert rst_n low after 3 beats -> slots all 0, no done, S_IDLE with cmd_ready=1 after release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared sizing and state encoding for the 1:32 burst-writing demultiplexer.
package demux_pkg;

  localparam int SLOTS = 32;
  localparam int SEL_W = 5;
  localparam int CNT_W = 6;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // Burst lengths above the slot count collapse to one full pass over every slot.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : c;
  endfunction

endpackage

// File: rtl/decoder_5_to_32.sv
// Enabled 5-bit to one-hot 32 decoder producing per-slot write enables.
module decoder_5_to_32
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [SLOTS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux32_burst_writer.sv
// Sequential 1:32 demultiplexer: accepts a (start slot, beat count) command and
// scatters a valid/ready beat stream into 32 slot registers with wrapping pointer.
//
//   state   | meaning
//   S_IDLE  | waiting for a burst command; cmd_ready high
//   S_BURST | accepting beats; remaining counts down to the last beat
module demux32_burst_writer
  import demux_pkg::*;
#(
  parameter int N = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SEL_W-1:0]   cmd_select,
  input  logic [CNT_W-1:0]   cmd_count,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  output logic [SLOTS*N-1:0] out,
  output logic [SLOTS-1:0]   wr_strobe,
  output logic               busy,
  output logic               done
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              done_q, done_d;
  logic [SLOTS-1:0]  wr_strobe_q;
  logic [SLOTS-1:0]  wen;
  logic              beat_fire;

  // Handshake readiness comes straight from the state register.
  assign cmd_ready = (state_q == S_IDLE);
  assign in_ready  = (state_q == S_BURST);
  assign busy      = (state_q == S_BURST);
  assign beat_fire = in_valid & in_ready;
  assign done      = done_q;
  assign wr_strobe = wr_strobe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      wr_strobe_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      wr_strobe_q <= wen;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            ptr_d   = cmd_select;
            rem_d   = sat_count(cmd_count);
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (in_valid) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  decoder_5_to_32 u_dec (
    .sel    (ptr_q),
    .en     (beat_fire),
    .onehot (wen)
  );

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [N-1:0] slot_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      slot_q <= '0;
      else if (wen[i]) slot_q <= in_data;
    end
    assign out[i*N +: N] = slot_q;
  end

endmodule
